// File: rtl/fp_convert_arbiter_if.sv
// Request, converter and response signals of the shared
// fp32-to-int32 converter arbiter.
interface fp_convert_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  unit_go;
  logic [31:0]           unit_a;
  logic                  unit_done;
  logic [31:0]           unit_result;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;

  modport slave (
    input  req_valid, req_data,
    input  unit_done, unit_result,
    input  resp_ready,
    output req_ready, unit_go, unit_a,
    output resp_valid, resp_id, resp_data
  );

  modport master (
    output req_valid, req_data,
    output unit_done, unit_result,
    output resp_ready,
    input  req_ready, unit_go, unit_a,
    input  resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/fp_convert_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fp32-to-int32
// converter, with credit-gated issue and a buffered response FIFO.
module fp_convert_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RESP_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  fp_convert_arbiter_if.slave  bus,
  output logic                 err
);
  localparam int ID_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W =
    (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C =
    (CNT_W + 1)'(RESP_DEPTH);
  localparam logic [ID_W-1:0] LAST_ID =
    ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] LAST_PTR =
    PTR_W'(RESP_DEPTH - 1);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               credit_ok;
  logic               hs;
  logic               done_ok;
  logic               pop;
  logic               go_q;
  logic [31:0]        a_q;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   resp_count;
  logic [PTR_W-1:0]   tag_wr;
  logic [PTR_W-1:0]   tag_rd;
  logic [PTR_W-1:0]   rsp_wr;
  logic [PTR_W-1:0]   rsp_rd;
  logic [ID_W-1:0]    tag_mem [RESP_DEPTH];
  logic [ID_W-1:0]    id_mem [RESP_DEPTH];
  logic [31:0]        data_mem [RESP_DEPTH];
  logic [31:0]        req_word [NUM_REQ];
  int                 idx;

  function automatic logic [PTR_W-1:0] bump(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = bus.req_data[32*i +: 32];
  end

  // Registered counts only: a same-cycle pop frees credit next cycle.
  assign credit_ok =
    ({1'b0, inflight} + {1'b0, resp_count}) < DEPTH_C;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[ID_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    if (found && credit_ok) grant[grant_idx] = 1'b1;
  end

  assign hs      = |grant;
  assign done_ok = bus.unit_done && (inflight != '0);
  assign pop     = bus.resp_valid && bus.resp_ready;

  assign bus.req_ready  = grant;
  assign bus.unit_go    = go_q;
  assign bus.unit_a     = a_q;
  assign bus.resp_valid = (resp_count != '0);
  assign bus.resp_id    = id_mem[rsp_rd];
  assign bus.resp_data  = data_mem[rsp_rd];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= LAST_ID;
      go_q       <= 1'b0;
      a_q        <= '0;
      inflight   <= '0;
      resp_count <= '0;
      tag_wr     <= '0;
      tag_rd     <= '0;
      rsp_wr     <= '0;
      rsp_rd     <= '0;
      err        <= 1'b0;
    end else begin
      go_q <= hs;
      if (hs) begin
        rr_ptr <= grant_idx;
        a_q    <= req_word[grant_idx];
        tag_wr <= bump(tag_wr);
      end
      if (done_ok) begin
        tag_rd <= bump(tag_rd);
        rsp_wr <= bump(rsp_wr);
      end
      if (pop) rsp_rd <= bump(rsp_rd);
      if (bus.unit_done && inflight == '0) err <= 1'b1;
      case ({hs, done_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      case ({done_ok, pop})
        2'b10:   resp_count <= resp_count + 1'b1;
        2'b01:   resp_count <= resp_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (hs) tag_mem[tag_wr] <= grant_idx;
    if (done_ok) begin
      id_mem[rsp_wr]   <= tag_mem[tag_rd];
      data_mem[rsp_wr] <= bus.unit_result;
    end
  end
endmodule

// File: tb/tb_fp_convert_arbiter.sv
// Bench for fp_convert_arbiter: behavioural 6-cycle converter,
// round-robin/credit model and in-order response scoreboard.
module tb_fp_convert_arbiter;
  localparam int NR    = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          t;
  } exp_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        err;
  logic        stray   = 1'b0;
  logic [5:0]  pv      = '0;
  logic [31:0] pa [6];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_ptr = NR - 1;
  int m_out = 0;
  int n_issue = 0;
  int n_pop   = 0;
  bit strict  = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_a  = '0;
  exp_t        sb [$];
  logic [3:0]  dlog [$];

  fp_convert_arbiter_if #(.NUM_REQ(NR)) bus();

  fp_convert_arbiter #(
    .NUM_REQ(NR),
    .RESP_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .err(err)
  );

  function automatic logic [31:0] fp2int(
    input logic [31:0] f
  );
    logic [31:0] m;
    logic [31:0] mag;
    int sh;
    m  = {8'd0, 1'b1, f[22:0]};
    sh = int'(f[30:23]) - 127;
    if (sh < 0) mag = '0;
    else if (sh <= 23) mag = m >> (23 - sh);
    else mag = m << (sh - 23);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] f;
    f[31]    = 1'($urandom_range(0, 1));
    f[30:23] = 8'(127 + $urandom_range(0, 20));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) pv <= '0;
    else begin
      pv    <= {pv[4:0], bus.unit_go};
      pa[0] <= bus.unit_a;
      for (int i = 1; i < 6; i++) pa[i] <= pa[i-1];
    end
  end

  assign bus.unit_done   = pv[5] | stray;
  assign bus.unit_result = fp2int(pa[5]);

  always @(negedge clock) begin : mon
    int e;
    int j;
    logic [3:0]  er;
    logic [31:0] w;
    exp_t x;
    bit p;
    if (!reset_n) begin
      sb.delete();
      m_ptr   = NR - 1;
      m_out   = 0;
      prev_hs = 1'b0;
      prev_a  = '0;
    end else begin
      e = -1;
      if (m_out < DEPTH)
        for (int k = 1; k <= NR; k++) begin
          j = (m_ptr + k) % NR;
          if (e < 0 && bus.req_valid[2'(j)]) e = j;
        end
      er = (e >= 0) ? 4'(1 << e) : 4'b0;
      if ((bus.req_valid & bus.req_ready) != 0)
        dlog.push_back(bus.req_ready);
      total++;
      if (bus.req_ready !== er) begin
        bad++;
        $display("FAIL grant cyc=%0d got=%b want=%b",
          cyc, bus.req_ready, er);
      end
      total++;
      if (bus.unit_go !== prev_hs) begin
        bad++;
        $display("FAIL unit_go cyc=%0d got=%b want=%b",
          cyc, bus.unit_go, prev_hs);
      end
      total++;
      if (bus.unit_a !== prev_a) begin
        bad++;
        $display("FAIL unit_a cyc=%0d got=%h want=%h",
          cyc, bus.unit_a, prev_a);
      end
      p = bus.resp_valid && bus.resp_ready;
      if (p) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL resp_extra cyc=%0d id=%0d data=%h",
            cyc, bus.resp_id, bus.resp_data);
        end else begin
          x = sb.pop_front();
          if (bus.resp_id !== x.id ||
              bus.resp_data !== x.data) begin
            bad++;
            $display("FAIL resp cyc=%0d got=%0d/%h want=%0d/%h",
              cyc, bus.resp_id, bus.resp_data, x.id, x.data);
          end
          total++;
          if (strict ? (cyc != x.t + 8) : (cyc < x.t + 8))
          begin
            bad++;
            $display("FAIL resp_time got=%0d want=%0d",
              cyc, x.t + 8);
          end
        end
      end
      prev_hs = (e >= 0);
      if (e >= 0) begin
        w      = 32'(bus.req_data >> (32 * e));
        x.id   = 2'(e);
        x.data = fp2int(w);
        x.t    = cyc;
        sb.push_back(x);
        m_ptr  = e;
        m_out++;
        n_issue++;
        prev_a = w;
      end
      if (p) begin
        m_out--;
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    total++;
    if (bus.unit_go !== 1'b0 || bus.unit_a !== 32'h0 ||
        bus.resp_valid !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs go=%b a=%h rv=%b err=%b",
        bus.unit_go, bus.unit_a, bus.resp_valid, err);
    end
    bus.req_valid = 4'hF;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_prio got=%b want=0001",
        bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int base;
    logic [3:0] want;
    base = n_pop;
    dlog.delete();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NR; i++)
      bus.req_data[32*i +: 32] = rnd_fp();
    bus.req_valid = 4'hF;
    repeat (8) tick();
    bus.req_valid = '0;
    repeat (20) tick();
    total++;
    if (dlog.size() != 8) begin
      bad++;
      $display("FAIL fair_count got=%0d want=8", dlog.size());
    end
    for (int i = 0; i < 8 && i < dlog.size(); i++) begin
      want = 4'(1 << (i % NR));
      total++;
      if (dlog[i] !== want) begin
        bad++;
        $display("FAIL fair_order i=%0d got=%b want=%b",
          i, dlog[i], want);
      end
    end
    total++;
    if (n_pop - base != 8) begin
      bad++;
      $display("FAIL fair_resp got=%0d want=8", n_pop - base);
    end
  endtask

  task automatic test_single_op();
    logic [31:0] ops [2];
    logic [31:0] res [2];
    ops[0] = 32'h41200000;
    ops[1] = 32'hC0A00000;
    res[0] = 32'h0000000A;
    res[1] = 32'hFFFFFFFB;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.req_data[95:64] = ops[k];
      bus.req_valid = 4'b0100;
      @(negedge clock);
      total++;
      if (bus.req_ready !== 4'b0100) begin
        bad++;
        $display("FAIL single_grant got=%b want=0100",
          bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      @(negedge clock);
      total++;
      if (bus.unit_go !== 1'b1 || bus.unit_a !== ops[k]) begin
        bad++;
        $display("FAIL single_go go=%b a=%h want 1/%h",
          bus.unit_go, bus.unit_a, ops[k]);
      end
      for (int c = 2; c <= 7; c++) begin
        tick();
        @(negedge clock);
        total++;
        if (bus.resp_valid !== 1'b0) begin
          bad++;
          $display("FAIL single_early T+%0d rv=%b want=0",
            c, bus.resp_valid);
        end
      end
      tick();
      @(negedge clock);
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 ||
          bus.resp_data !== res[k]) begin
        bad++;
        $display("FAIL single_resp rv=%b id=%0d d=%h want 1/2/%h",
          bus.resp_valid, bus.resp_id, bus.resp_data, res[k]);
      end
      tick();
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 1'b0;
    dlog.delete();
    for (int i = 0; i < NR; i++)
      bus.req_data[32*i +: 32] = rnd_fp();
    bus.req_valid = 4'hF;
    repeat (14) tick();
    @(negedge clock);
    total++;
    if (dlog.size() != DEPTH || bus.req_ready !== 4'b0) begin
      bad++;
      $display("FAIL bp_full grants=%0d ready=%b want 8/0000",
        dlog.size(), bus.req_ready);
    end
    tick();
    bus.resp_ready = 1'b1;
    @(negedge clock);
    total++;
    if (bus.req_ready !== 4'b0) begin
      bad++;
      $display("FAIL bp_popcyc ready=%b want=0000",
        bus.req_ready);
    end
    tick();
    bus.resp_ready = 1'b0;
    @(negedge clock);
    total++;
    if (bus.req_ready === 4'b0) begin
      bad++;
      $display("FAIL bp_regrant ready=%b want=onehot",
        bus.req_ready);
    end
    repeat (3) tick();
    total++;
    if (dlog.size() != DEPTH + 1) begin
      bad++;
      $display("FAIL bp_extra grants=%0d want=9", dlog.size());
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    repeat (20) tick();
    total++;
    if (sb.size() != 0 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain left=%0d rv=%b want 0/0",
        sb.size(), bus.resp_valid);
    end
  endtask

  task automatic test_streaming();
    int base;
    int guard;
    base  = n_pop;
    guard = 0;
    strict = 1'b1;
    dlog.delete();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b0010;
    while (dlog.size() < 20 && guard < 60) begin
      bus.req_data[63:32] = rnd_fp();
      tick();
      guard++;
    end
    bus.req_valid = '0;
    total++;
    if (guard >= 60) begin
      bad++;
      $display("FAIL stream_timeout grants=%0d want=20",
        dlog.size());
    end
    repeat (15) tick();
    total++;
    if (n_pop - base != 20 || sb.size() != 0) begin
      bad++;
      $display("FAIL stream_resp got=%0d left=%0d want 20/0",
        n_pop - base, sb.size());
    end
    strict = 1'b0;
  endtask

  task automatic test_simultaneous();
    int bi;
    int bp;
    bi = n_issue;
    bp = n_pop;
    repeat (200) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < NR; i++)
        bus.req_data[32*i +: 32] = rnd_fp();
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    repeat (20) tick();
    total++;
    if (n_pop - bp != n_issue - bi || sb.size() != 0 ||
        bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL simul pops=%0d issues=%0d left=%0d rv=%b",
        n_pop - bp, n_issue - bi, sb.size(), bus.resp_valid);
    end
  endtask

  task automatic test_reset_error();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'hF;
    repeat (10) tick();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.unit_go !== 1'b0 || bus.unit_a !== 32'h0 ||
        bus.resp_valid !== 1'b0 || err !== 1'b0 ||
        bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midreset go=%b a=%h rv=%b err=%b rdy=%b",
        bus.unit_go, bus.unit_a, bus.resp_valid, err,
        bus.req_ready);
    end
    bus.req_valid = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    @(negedge clock);
    total++;
    if (err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL stray err=%b rv=%b want 1/0",
        err, bus.resp_valid);
    end
    repeat (3) tick();
    @(negedge clock);
    total++;
    if (err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL sticky err=%b rv=%b want 1/0",
        err, bus.resp_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_single_op();
    test_backpressure();
    test_streaming();
    test_simultaneous();
    test_reset_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
